// File: rtl/cpu_params_pkg.sv
// Shared CPU-wide sizing parameters.
package cpu_params_pkg;

  localparam int unsigned PC_SZ = 32;

endpackage : cpu_params_pkg

// File: rtl/cpu_structs_pkg.sv
// Shared CPU-wide enums and structs.
package cpu_structs_pkg;

  // Branch redirect controller sequencer states.
  typedef enum logic {
    BRC_IDLE     = 1'b0,
    BRC_REDIRECT = 1'b1
  } BRC_STATE_TYPE;

endpackage : cpu_structs_pkg

// File: rtl/br_stat_cnt.sv
// Branch statistics: counts resolved branches and mispredicts (wrapping counters).
// Instantiated by br_redirect_ctrl only when BR_STATS_EN is defined.
module br_stat_cnt #(
  parameter int unsigned CNT_SZ = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              take,
  input  logic              mispred,
  output logic [CNT_SZ-1:0] br_cnt,
  output logic [CNT_SZ-1:0] mispred_cnt
);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (take)    br_cnt      <= br_cnt + CNT_SZ'(1);
      if (mispred) mispred_cnt <= mispred_cnt + CNT_SZ'(1);
    end
  end

endmodule : br_stat_cnt

// File: rtl/br_redirect_ctrl.sv
// Branch redirect sequencer between the EXE branch unit and fetch: flush + redirect on
// mispredict, misaligned-target exception otherwise. Optional statistics via BR_STATS_EN.
module br_redirect_ctrl
  import cpu_structs_pkg::*;
#(
  parameter int unsigned PC_SZ = cpu_params_pkg::PC_SZ
`ifdef BR_STATS_EN
  ,
  parameter int unsigned CNT_SZ = 32
`endif
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             exe_valid,
  input  logic             exe_is_br,
  input  logic [PC_SZ-1:0] exe_pc,
  input  logic [PC_SZ-1:0] exe_br_pc,
  input  logic [PC_SZ-1:0] exe_pred_pc,
  input  logic             exe_mis,
  input  logic             trap_flush_in,
  output logic             exe_stall,
  output logic             flush_out,
  output logic             rdr_valid,
  output logic [PC_SZ-1:0] rdr_pc,
  input  logic             rdr_ready,
  output logic             exc_req,
  output logic [PC_SZ-1:0] exc_pc,
  output logic [PC_SZ-1:0] exc_tval
`ifdef BR_STATS_EN
  ,
  output logic [CNT_SZ-1:0] br_cnt,
  output logic [CNT_SZ-1:0] mispred_cnt
`endif
);

  BRC_STATE_TYPE    state_q, state_d;
  logic             take_c, mispred_c, misalign_c;
  logic             flush_d, rdr_valid_d, exc_req_d;
  logic [PC_SZ-1:0] rdr_pc_d, exc_pc_d, exc_tval_d;

  assign exe_stall  = (state_q == BRC_REDIRECT);
  assign take_c     = exe_valid & exe_is_br & ~exe_stall & ~trap_flush_in;
  assign misalign_c = take_c & exe_mis;
  assign mispred_c  = take_c & ~exe_mis & (exe_br_pc != exe_pred_pc);

  // Next state and next registered outputs; a trap flush overrides everything.
  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    exc_req_d  = 1'b0;
    rdr_pc_d   = rdr_pc;
    exc_pc_d   = exc_pc;
    exc_tval_d = exc_tval;
    case (state_q)
      BRC_IDLE: begin
        if (mispred_c) begin
          state_d  = BRC_REDIRECT;
          flush_d  = 1'b1;
          rdr_pc_d = exe_br_pc;
        end else if (misalign_c) begin
          exc_req_d  = 1'b1;
          exc_pc_d   = exe_pc;
          exc_tval_d = exe_br_pc;
        end
      end
      BRC_REDIRECT: begin
        if (rdr_ready) state_d = BRC_IDLE;
      end
      default: state_d = BRC_IDLE;
    endcase
    if (trap_flush_in) state_d = BRC_IDLE;
    rdr_valid_d = (state_d == BRC_REDIRECT);
    // Redirect target reads as zero whenever no request is outstanding.
    if (!rdr_valid_d) rdr_pc_d = '0;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= BRC_IDLE;
      flush_out <= 1'b0;
      rdr_valid <= 1'b0;
      rdr_pc    <= '0;
      exc_req   <= 1'b0;
      exc_pc    <= '0;
      exc_tval  <= '0;
    end else begin
      state_q   <= state_d;
      flush_out <= flush_d;
      rdr_valid <= rdr_valid_d;
      rdr_pc    <= rdr_pc_d;
      exc_req   <= exc_req_d;
      exc_pc    <= exc_pc_d;
      exc_tval  <= exc_tval_d;
    end
  end

`ifdef BR_STATS_EN
  br_stat_cnt #(
    .CNT_SZ (CNT_SZ)
  ) u_br_stat_cnt (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .take        (take_c),
    .mispred     (mispred_c),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );
`endif

endmodule : br_redirect_ctrl

// File: tb/tb_br_redirect_ctrl.sv
// Scoreboard bench for br_redirect_ctrl: directed test-plan cases plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_br_redirect_ctrl;

  localparam int unsigned PC_SZ  = 32;
  localparam int unsigned CNT_SZ = 4;

  logic             clk_in = 1'b0;
  logic             reset_in;
  logic             exe_valid, exe_is_br, exe_mis, trap_flush_in, rdr_ready;
  logic [PC_SZ-1:0] exe_pc, exe_br_pc, exe_pred_pc;
  logic             exe_stall, flush_out, rdr_valid, exc_req;
  logic [PC_SZ-1:0] rdr_pc, exc_pc, exc_tval;
  logic [CNT_SZ-1:0] br_cnt_w, mispred_cnt_w;

  always #5 clk_in = ~clk_in;

`ifdef BR_STATS_EN
  br_redirect_ctrl #(.PC_SZ(PC_SZ), .CNT_SZ(CNT_SZ)) dut (
`else
  br_redirect_ctrl #(.PC_SZ(PC_SZ)) dut (
`endif
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .exe_valid     (exe_valid),
    .exe_is_br     (exe_is_br),
    .exe_pc        (exe_pc),
    .exe_br_pc     (exe_br_pc),
    .exe_pred_pc   (exe_pred_pc),
    .exe_mis       (exe_mis),
    .trap_flush_in (trap_flush_in),
    .exe_stall     (exe_stall),
    .flush_out     (flush_out),
    .rdr_valid     (rdr_valid),
    .rdr_pc        (rdr_pc),
    .rdr_ready     (rdr_ready),
    .exc_req       (exc_req),
    .exc_pc        (exc_pc),
    .exc_tval      (exc_tval)
`ifdef BR_STATS_EN
    ,
    .br_cnt        (br_cnt_w),
    .mispred_cnt   (mispred_cnt_w)
`endif
  );

`ifndef BR_STATS_EN
  assign br_cnt_w      = '0;
  assign mispred_cnt_w = '0;
`endif

  typedef struct packed {
    logic              stall;
    logic              flush;
    logic              rv;
    logic [PC_SZ-1:0]  rpc;
    logic              exc;
    logic [PC_SZ-1:0]  epc;
    logic [PC_SZ-1:0]  etv;
    logic [CNT_SZ-1:0] brc;
    logic [CNT_SZ-1:0] mpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Reference model: outstanding redirect targets kept as a queue (at most one entry).
  logic [PC_SZ-1:0]  outstanding[$];
  logic [PC_SZ-1:0]  m_epc, m_etv;
  logic [CNT_SZ-1:0] m_br, m_mp;

  task automatic chk(input string nm, input logic [PC_SZ-1:0] act, input logic [PC_SZ-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    outstanding.delete();
    m_epc = '0;
    m_etv = '0;
    m_br  = '0;
    m_mp  = '0;
  endtask

  // Drive one cycle of inputs (optionally pulsing async reset first) and push the
  // expected post-edge outputs.
  task automatic step(input logic v, input logic br, input logic [PC_SZ-1:0] pc,
                      input logic [PC_SZ-1:0] brpc, input logic [PC_SZ-1:0] pred,
                      input logic mis, input logic trap, input logic rdy, input logic rp);
    exp_t e;
    bit   busy, tk, f, x;
    @(negedge clk_in);
    if (rp) begin
      #1 reset_in = 1'b1;
      #1;
      chk("async_rst_rdr_valid", PC_SZ'(rdr_valid), '0);
      chk("async_rst_exe_stall", PC_SZ'(exe_stall), '0);
      chk("async_rst_rdr_pc", rdr_pc, '0);
      #1 reset_in = 1'b0;
      model_reset();
    end
    exe_valid = v; exe_is_br = br; exe_pc = pc; exe_br_pc = brpc; exe_pred_pc = pred;
    exe_mis = mis; trap_flush_in = trap; rdr_ready = rdy;
    busy = (outstanding.size() != 0);
    tk   = v && br && !busy && !trap;
    f = 1'b0;
    x = 1'b0;
    if (tk) m_br = m_br + 1'b1;
    if (trap) outstanding.delete();
    else if (busy) begin
      if (rdy) void'(outstanding.pop_front());
    end else if (tk && mis) begin
      x = 1'b1; m_epc = pc; m_etv = brpc;
    end else if (tk && brpc != pred) begin
      f = 1'b1; outstanding.push_back(brpc); m_mp = m_mp + 1'b1;
    end
    e.stall = (outstanding.size() != 0);
    e.rv    = e.stall;
    e.rpc   = e.stall ? outstanding[0] : '0;
    e.flush = f;
    e.exc   = x;
    e.epc   = m_epc;
    e.etv   = m_etv;
    e.brc   = m_br;
    e.mpc   = m_mp;
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: after every edge pop the expected response and compare it with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("exe_stall", PC_SZ'(exe_stall), PC_SZ'(e.stall));
          chk("flush_out", PC_SZ'(flush_out), PC_SZ'(e.flush));
          chk("rdr_valid", PC_SZ'(rdr_valid), PC_SZ'(e.rv));
          chk("rdr_pc", rdr_pc, e.rpc);
          chk("exc_req", PC_SZ'(exc_req), PC_SZ'(e.exc));
          chk("exc_pc", exc_pc, e.epc);
          chk("exc_tval", exc_tval, e.etv);
`ifdef BR_STATS_EN
          chk("br_cnt", PC_SZ'(br_cnt_w), PC_SZ'(e.brc));
          chk("mispred_cnt", PC_SZ'(mispred_cnt_w), PC_SZ'(e.mpc));
`endif
        end
      end
    end
  end

  initial begin
    logic [PC_SZ-1:0] rpc, rbr, rpred;
    reset_in = 1'b1;
    exe_valid = 1'b0; exe_is_br = 1'b0; exe_mis = 1'b0; trap_flush_in = 1'b0; rdr_ready = 1'b0;
    exe_pc = '0; exe_br_pc = '0; exe_pred_pc = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    chk("reset_exe_stall", PC_SZ'(exe_stall), '0);
    chk("reset_flush_out", PC_SZ'(flush_out), '0);
    chk("reset_rdr_valid", PC_SZ'(rdr_valid), '0);
    chk("reset_rdr_pc", rdr_pc, '0);
    chk("reset_exc_req", PC_SZ'(exc_req), '0);
    chk("reset_exc_pc", exc_pc, '0);
    chk("reset_exc_tval", exc_tval, '0);

    // Mispredict with fetch always ready, then a correctly predicted branch.
    step(1, 1, 32'h100, 32'h200, 32'h104, 0, 0, 1, 0);
    idle(1);
    step(1, 1, 32'h300, 32'h304, 32'h304, 0, 0, 1, 0);
    idle(1);
    // Fetch holds off for 3 cycles; a branch offered while stalled is ignored.
    step(1, 1, 32'h100, 32'h200, 32'h104, 0, 0, 0, 0);
    step(1, 1, 32'h500, 32'h600, 32'h504, 0, 0, 0, 0);
    idle(0);
    idle(0);
    step(1, 1, 32'h700, 32'h800, 32'h704, 0, 0, 1, 0);
    step(1, 1, 32'h900, 32'hA00, 32'h904, 0, 0, 1, 0);
    idle(1);
    // Misaligned target, and rdr_ready high with nothing outstanding.
    step(1, 1, 32'h100, 32'h202, 32'h104, 1, 0, 1, 0);
    idle(1);
    // Trap wins over a same-cycle mispredict, and cancels an outstanding redirect.
    step(1, 1, 32'h100, 32'h200, 32'h104, 0, 1, 0, 0);
    step(1, 1, 32'h100, 32'h200, 32'h104, 0, 0, 0, 0);
    step(0, 0, '0, '0, '0, 0, 1, 0, 0);
    idle(0);
    // Async reset between edges while a redirect is pending.
    step(1, 1, 32'h100, 32'h200, 32'h104, 0, 0, 0, 0);
    idle(0);
    step(0, 0, '0, '0, '0, 0, 0, 0, 1);
    idle(1);

`ifdef BR_STATS_EN
    // 10 branches: 3 mispredict, 1 misaligned; then 6 more to wrap the 4-bit counter.
    step(0, 0, '0, '0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16),
           (i < 3) ? 32'h3000 : 32'h2000 + 32'(i * 16), (i == 5), 0, 1, 0);
      idle(1);
    end
    @(posedge clk_in);
    #2;
    chk("stats_br_cnt_10", PC_SZ'(br_cnt_w), 32'd10);
    chk("stats_mispred_cnt_3", PC_SZ'(mispred_cnt_w), 32'd3);
    for (int i = 0; i < 6; i++) step(1, 1, 32'h40, 32'h80, 32'h80, 0, 0, 1, 0);
    idle(1);
    @(posedge clk_in);
    #2;
    chk("stats_br_cnt_wrap", PC_SZ'(br_cnt_w), 32'd0);
    chk("stats_mispred_hold", PC_SZ'(mispred_cnt_w), 32'd3);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rpc   = $urandom() & 32'hFFFF_FFFC;
      rbr   = $urandom() & 32'hFFFF_FFFE;
      rpred = ($urandom_range(0, 1) == 0) ? rbr : ($urandom() & 32'hFFFF_FFFE);
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), rpc, rbr, rpred,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
    end
    idle(1);
    @(posedge clk_in);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_br_redirect_ctrl
